// File: rtl/iommu_bridge_pkg.sv
// Shared types for the IOMMU regbus/AXI bridges: FSM states, AXI constants, default struct types.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package iommu_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DRAIN
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // Default struct layout; integrators normally pass their own fabric types.
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ID_WIDTH   = 4;
    localparam int unsigned DEF_USER_WIDTH = 1;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [DEF_USER_WIDTH-1:0] user;
    } def_axi_aw_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [DEF_USER_WIDTH-1:0] user;
    } def_axi_ar_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]   data;
        logic [DEF_DATA_WIDTH/8-1:0] strb;
        logic                        last;
        logic [DEF_USER_WIDTH-1:0]   user;
    } def_axi_w_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [DEF_USER_WIDTH-1:0] user;
    } def_axi_b_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [DEF_USER_WIDTH-1:0] user;
    } def_axi_r_t;

    typedef struct packed {
        def_axi_aw_t aw;
        logic        aw_valid;
        def_axi_w_t  w;
        logic        w_valid;
        logic        b_ready;
        def_axi_ar_t ar;
        logic        ar_valid;
        logic        r_ready;
    } def_axi_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       ar_ready;
        logic       w_ready;
        logic       b_valid;
        def_axi_b_t b;
        logic       r_valid;
        def_axi_r_t r;
    } def_axi_rsp_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic                        write;
        logic [DEF_DATA_WIDTH-1:0]   wdata;
        logic [DEF_DATA_WIDTH/8-1:0] wstrb;
        logic                        valid;
    } def_reg_req_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      ready;
    } def_reg_rsp_t;

endpackage

// File: rtl/iommu_reg2axi_wdog.sv
// Response watchdog: counts cycles while cnt_en_i, flags expiry on the LIMIT-th cycle, clr_i rearms.
// Latency: expired_o is combinational on the LIMIT-th counted cycle.
// Backpressure: none; the counter freezes once expired until cleared.
module iommu_reg2axi_wdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = cnt_en_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/iommu_reg_to_axi.sv
// Regbus-to-AXI4 bridge, one single-beat transaction outstanding; IOMMU_REG2AXI_TIMEOUT_EN adds a response watchdog.
// Latency: ready 2 cycles after valid with a zero-wait slave (capture, request, response).
// Backpressure: AW/W/AR held until their handshakes, regbus held until the B/R response.
module iommu_reg_to_axi
    import iommu_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
    parameter int unsigned USER_WIDTH     = DEF_USER_WIDTH,
    parameter logic [ID_WIDTH-1:0] AXI_ID = '0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter type axi_req_t = def_axi_req_t,
    parameter type axi_rsp_t = def_axi_rsp_t,
    parameter type reg_req_t = def_reg_req_t,
    parameter type reg_rsp_t = def_reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output axi_req_t axi_req_o,
    input  axi_rsp_t axi_rsp_i
);
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_done_q, w_done_q;
    logic                    aw_hs, w_hs, timeout;

    assign aw_hs = (state_q == WR_REQ) && !aw_done_q && axi_rsp_i.aw_ready;
    assign w_hs  = (state_q == WR_REQ) && !w_done_q  && axi_rsp_i.w_ready;

`ifdef IOMMU_REG2AXI_TIMEOUT_EN
    iommu_reg2axi_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     ((state_q == WR_REQ) || (state_q == RD_REQ)),
        .cnt_en_i  ((state_q == WR_RSP) || (state_q == RD_RSP)),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && reg_req_i.valid) begin
                addr_q  <= reg_req_i.addr;
                wdata_q <= reg_req_i.wdata;
                wstrb_q <= reg_req_i.wstrb;
            end
            // Sticky per-channel flags so a W accepted early is never re-sent while AW waits.
            if (state_q == WR_REQ) begin
                aw_done_q <= aw_done_q | aw_hs;
                w_done_q  <= w_done_q | w_hs;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        axi_req_o = '0;
        reg_rsp_o = '0;

        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = axi_size(DATA_WIDTH);
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.aw.user  = USER_WIDTH'(0);
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = axi_size(DATA_WIDTH);
        axi_req_o.ar.burst = AXI_BURST_INCR;
        axi_req_o.ar.user  = USER_WIDTH'(0);
        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = wstrb_q;
        axi_req_o.w.last   = 1'b1;

        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    state_d = reg_req_i.write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                axi_req_o.aw_valid = !aw_done_q;
                axi_req_o.w_valid  = !w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    reg_rsp_o.ready = 1'b1;
                    reg_rsp_o.error = axi_rsp_i.b.resp[1];
                    state_d         = IDLE;
                end else if (timeout) begin
                    reg_rsp_o.ready = 1'b1;
                    reg_rsp_o.error = 1'b1;
                    state_d         = DRAIN;
                end
            end
            RD_REQ: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_rsp_i.ar_ready) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                axi_req_o.r_ready = 1'b1;
                if (axi_rsp_i.r_valid) begin
                    reg_rsp_o.ready = 1'b1;
                    reg_rsp_o.rdata = axi_rsp_i.r.data;
                    reg_rsp_o.error = axi_rsp_i.r.resp[1];
                    state_d         = IDLE;
                end else if (timeout) begin
                    reg_rsp_o.ready = 1'b1;
                    reg_rsp_o.error = 1'b1;
                    state_d         = DRAIN;
                end
            end
`ifdef IOMMU_REG2AXI_TIMEOUT_EN
            DRAIN: begin
                // The requester was already answered; swallow the late response.
                axi_req_o.b_ready = 1'b1;
                axi_req_o.r_ready = 1'b1;
                if (axi_rsp_i.b_valid || axi_rsp_i.r_valid) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iommu_reg_to_axi.sv
// Directed bench for iommu_reg_to_axi: programmable AXI slave, regbus requester task, handshake monitor.
module tb_iommu_reg_to_axi;
    import iommu_bridge_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    def_reg_req_t reg_req = '0;
    def_reg_rsp_t reg_rsp;
    def_axi_req_t axi_req;
    def_axi_rsp_t axi_rsp = '0;

    always #5 clk = ~clk;

    iommu_reg_to_axi #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .ID_WIDTH       (4),
        .USER_WIDTH     (1),
        .AXI_ID         (4'h5),
        .TIMEOUT_CYCLES (8),
        .axi_req_t      (def_axi_req_t),
        .axi_rsp_t      (def_axi_rsp_t),
        .reg_req_t      (def_reg_req_t),
        .reg_rsp_t      (def_reg_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp),
        .axi_req_o (axi_req),
        .axi_rsp_i (axi_rsp)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave knobs, changed by the stimulus only at negedges
    int         aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    bit         r_mute = 1'b0;
    int         aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0;

    always @(posedge clk) begin
        #1;
        if (axi_req.aw_valid) begin axi_rsp.aw_ready = (aw_age >= aw_wait); aw_age++; end
        else begin axi_rsp.aw_ready = 1'b0; aw_age = 0; end
        if (axi_req.w_valid) begin axi_rsp.w_ready = (w_age >= w_wait); w_age++; end
        else begin axi_rsp.w_ready = 1'b0; w_age = 0; end
        if (axi_req.ar_valid) begin axi_rsp.ar_ready = (ar_age >= ar_wait); ar_age++; end
        else begin axi_rsp.ar_ready = 1'b0; ar_age = 0; end
        if (axi_req.b_ready) begin
            axi_rsp.b_valid = (b_age >= b_wait);
            axi_rsp.b.resp  = bresp_cfg;
            b_age++;
        end else begin
            axi_rsp.b_valid = 1'b0; b_age = 0;
        end
        if (axi_req.r_ready && !r_mute) begin
            axi_rsp.r_valid = (r_age >= r_wait);
            axi_rsp.r.data  = rdata_cfg;
            axi_rsp.r.resp  = rresp_cfg;
            axi_rsp.r.last  = 1'b1;
            r_age++;
        end else begin
            axi_rsp.r_valid = 1'b0; r_age = 0;
        end
    end

    int          aw_n = 0, w_n = 0, ar_n = 0, aw_only_n = 0;
    def_axi_aw_t last_aw;
    def_axi_w_t  last_w;
    def_axi_ar_t last_ar;

    always @(posedge clk) begin
        if (rst_n) begin
            if (axi_req.aw_valid && axi_rsp.aw_ready) begin aw_n++; last_aw = axi_req.aw; end
            if (axi_req.w_valid && axi_rsp.w_ready) begin w_n++; last_w = axi_req.w; end
            if (axi_req.ar_valid && axi_rsp.ar_ready) begin ar_n++; last_ar = axi_req.ar; end
            if (axi_req.aw_valid && !axi_req.w_valid) aw_only_n++;
        end
    end

    logic [31:0] rd;
    logic        er;
    int          lat;

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                          output int cycles);
        @(negedge clk);
        reg_req.addr  = addr;
        reg_req.write = wr;
        reg_req.wdata = wdata;
        reg_req.wstrb = strb;
        reg_req.valid = 1'b1;
        cycles = 0;
        rdata  = '0;
        err    = 1'b0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (reg_rsp.ready) begin
                rdata = reg_rsp.rdata;
                err   = reg_rsp.error;
                break;
            end
            if (cycles >= 200) begin
                check_eq("req_bound", reg_rsp.ready, 1'b1);
                break;
            end
        end
        reg_req.valid = 1'b0;
        @(negedge clk);
        check_eq("ready_pulse", reg_rsp.ready, 1'b0);
    endtask

    int ar0, aw0, w0, awo0;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_axi_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                    axi_req.b_ready, axi_req.r_ready}, 5'b0);
        check_eq("rst_reg_rsp", {reg_rsp.ready, reg_rsp.error, reg_rsp.rdata}, 34'h0);
        rst_n = 1'b1;

        // Zero-wait write
        aw0 = aw_n; w0 = w_n; ar0 = ar_n;
        do_req(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check_eq("wr_latency", lat, 2);
        check_eq("wr_error", er, 1'b0);
        check_eq("wr_rdata_zero", rd, 32'h0);
        check_eq("wr_aw_count", aw_n - aw0, 1);
        check_eq("wr_w_count", w_n - w0, 1);
        check_eq("wr_ar_count", ar_n - ar0, 0);
        check_eq("aw_addr", last_aw.addr, 32'h1000);
        check_eq("aw_id_len_size_burst", {last_aw.id, last_aw.len, last_aw.size, last_aw.burst},
                 {4'h5, 8'h00, 3'd2, 2'b01});
        check_eq("aw_misc_zero", {last_aw.lock, last_aw.cache, last_aw.prot, last_aw.qos,
                                  last_aw.region, last_aw.atop, last_aw.user}, 0);
        check_eq("w_beat", {last_w.data, last_w.strb, last_w.last}, {32'hDEAD_BEEF, 4'hF, 1'b1});

        // Read with 5 wait cycles on R
        r_wait = 5; rdata_cfg = 32'h1234_5678;
        ar0 = ar_n; aw0 = aw_n;
        do_req(1'b0, 32'h2008, 32'h0, 4'h0, rd, er, lat);
        check_eq("rd_latency", lat, 7);
        check_eq("rd_rdata", rd, 32'h1234_5678);
        check_eq("rd_error", er, 1'b0);
        check_eq("rd_ar_count", ar_n - ar0, 1);
        check_eq("rd_aw_count", aw_n - aw0, 0);
        check_eq("ar_fields", {last_ar.addr, last_ar.id, last_ar.len, last_ar.size, last_ar.burst},
                 {32'h2008, 4'h5, 8'h00, 3'd2, 2'b01});
        r_wait = 0;

        // AW accepted 3 cycles after W
        aw_wait = 3; w_wait = 0;
        aw0 = aw_n; w0 = w_n; awo0 = aw_only_n;
        do_req(1'b1, 32'h1100, 32'hCAFE_F00D, 4'h3, rd, er, lat);
        check_eq("split_latency", lat, 5);
        check_eq("split_aw_only_cycles", aw_only_n - awo0, 3);
        check_eq("split_w_count", w_n - w0, 1);
        check_eq("split_aw_count", aw_n - aw0, 1);
        check_eq("split_w_strb", last_w.strb, 4'h3);
        check_eq("split_error", er, 1'b0);
        aw_wait = 0;

        // Error responses
        rresp_cfg = 2'b11; rdata_cfg = 32'hAAAA_5555;
        do_req(1'b0, 32'h2100, 32'h0, 4'h0, rd, er, lat);
        check_eq("decerr_read", er, 1'b1);
        bresp_cfg = 2'b10;
        do_req(1'b1, 32'h1200, 32'h1, 4'h1, rd, er, lat);
        check_eq("slverr_write", er, 1'b1);
        bresp_cfg = 2'b01;
        do_req(1'b1, 32'h1204, 32'h2, 4'h1, rd, er, lat);
        check_eq("exokay_write", er, 1'b0);
        rresp_cfg = 2'b00; rdata_cfg = 32'h0F0F_1234;
        do_req(1'b0, 32'h2200, 32'h0, 4'h0, rd, er, lat);
        check_eq("okay_read_err", er, 1'b0);
        check_eq("okay_read_data", rd, 32'h0F0F_1234);
        bresp_cfg = 2'b00;

        // Reset while waiting in RD_RSP
        r_mute = 1'b1; ar0 = ar_n;
        @(negedge clk);
        reg_req.addr = 32'h3000; reg_req.write = 1'b0; reg_req.valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_r_ready", axi_req.r_ready, 1'b1);
        rst_n = 1'b0;
        reg_req.valid = 1'b0;
        #1;
        check_eq("midrst_axi_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                       axi_req.b_ready, axi_req.r_ready}, 5'b0);
        check_eq("midrst_reg_ready", reg_rsp.ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; r_mute = 1'b0; rdata_cfg = 32'h0BAD_F00D;
        do_req(1'b0, 32'h4000, 32'h0, 4'h0, rd, er, lat);
        check_eq("postrst_latency", lat, 2);
        check_eq("postrst_rdata", rd, 32'h0BAD_F00D);
        check_eq("postrst_ar_count", ar_n - ar0, 2);

`ifdef IOMMU_REG2AXI_TIMEOUT_EN
        // Slave silent: watchdog answers, late R is drained, next read is fresh
        r_mute = 1'b1; ar0 = ar_n; rdata_cfg = 32'h7777_7777;
        do_req(1'b0, 32'h5000, 32'h0, 4'h0, rd, er, lat);
        check_eq("to_latency", lat, 9);
        check_eq("to_error", er, 1'b1);
        check_eq("to_rdata", rd, 32'h0);
        check_eq("drain_r_ready", axi_req.r_ready, 1'b1);
        r_mute = 1'b0;
        @(negedge clk);
        check_eq("drain_late_r_seen", axi_rsp.r_valid, 1'b1);
        check_eq("drain_no_ready", reg_rsp.ready, 1'b0);
        rdata_cfg = 32'h5A5A_0001;
        do_req(1'b0, 32'h6000, 32'h0, 4'h0, rd, er, lat);
        check_eq("post_to_latency", lat, 2);
        check_eq("post_to_rdata", rd, 32'h5A5A_0001);
        check_eq("post_to_error", er, 1'b0);
        check_eq("post_to_ar_count", ar_n - ar0, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
